// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared constants, types and hex segment table for seg7_scan.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] digit_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/seg7_scan_hex_to_seg7.sv
// ============================================================================
// Module  : hex_to_seg7
// Brief   : Combinational 4-bit to active-low 7-segment decoder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan.sv
// ============================================================================
// Module  : seg7_scan
// Brief   : Snapshot a 16-bit value and scan it as 4 hex digits with blanking.
//           Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        btnac,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [15:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    digit_t           digit_q, digit_d;
    logic [3:0]       an_q,   an_d;
    logic [6:0]       seg_q,  seg_d;

    phase_t     phase;
    logic [3:0] nibble;
    logic [6:0] seg_dec;
    logic       digit_lit;

    assign phase  = (cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;
    assign nibble = snap_q[{digit_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_dec)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Highest nonzero nibble; digit 0 stays lit even when the snapshot is zero.
    digit_t msd;
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (snap_q[4*k +: 4] != 4'h0) begin
                msd = digit_t'(k);
            end
        end
    end
    assign digit_lit = (digit_q <= msd);
`else
    assign digit_lit = 1'b1;
`endif

    always_comb begin
        snap_d  = snap_q;
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        an_d    = 4'b1111;
        seg_d   = SEG_BLANK;

        if (load) begin
            snap_d = value;
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 1'b1;
        end

        // Outputs are built from the pre-edge state, hence one cycle of lag.
        if ((phase == PH_DRIVE) && digit_lit) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (btnac) begin
            snap_q  <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

`default_nettype wire
